rx_block_sync: RTL and testbench



---
 rtl/pcs_pkg.sv | 20 ++
 rtl/rx_gearbox_32_66.sv | 36 +++
 rtl/rx_block_sync.sv | 106 ++++++++++
 tb/tb_rx_block_sync.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// pcs_pkg: shared 10GBASE-R PCS block constants, lock FSM states and header check
package pcs_pkg;

    localparam int         BLK_W   = 66;
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic [1:0] {
        LOCK_INIT,
        TEST_SH,
        SLIP,
        SLIP_WAIT
    } blk_sync_state_t;

    // A sync header is valid only when its two bits differ
    function automatic logic sh_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/rx_gearbox_32_66.sv
// rx_gearbox_32_66: packs 32-bit PMA words into 66-bit blocks, 16 blocks per 33 words
module rx_gearbox_32_66 import pcs_pkg::*; (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_data,
    output logic [BLK_W-1:0] o_blk,
    output logic             o_blk_stb
);

    localparam int BUF_W = 98;

    logic [BUF_W-1:0] r_buf;
    logic [6:0]       r_cnt;
    logic [BUF_W-1:0] w_buf_add;
    logic [6:0]       w_cnt_add;

    // Append the new word above the buffered bits; a block is ready once 66 bits are held
    always_comb begin
        w_buf_add = r_buf | ({66'd0, i_data} << r_cnt);
        w_cnt_add = r_cnt + 7'd32;
        o_blk_stb = w_cnt_add >= 7'd66;
        o_blk     = w_buf_add[BLK_W-1:0];
    end

    // Retire a presented block from the bottom of the buffer
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else begin
            r_buf <= o_blk_stb ? (w_buf_add >> BLK_W) : w_buf_add;
            r_cnt <= o_blk_stb ? (w_cnt_add - 7'd66) : w_cnt_add;
        end
    end

endmodule

// File: rtl/rx_block_sync.sv
// rx_block_sync: 10GBASE-R block synchroniser with 32:66 gearbox, lock FSM and PMA bit-slip
module rx_block_sync #(
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_WAIT    = 32
) (
    input  logic                      i_pma_rx_clk,
    input  logic                      i_pma_rx_rst_n,
    input  logic [31:0]               i_pma_rx,
    output logic                      o_pma_slip,
    output logic [pcs_pkg::BLK_W-1:0] o_blk_data,
    output logic                      o_blk_valid,
    output logic                      o_blk_lock
);

    import pcs_pkg::*;

    localparam int         WAIT_W  = $clog2(SLIP_WAIT + 1);
    localparam logic [6:0] CNT_MAX = 7'(SH_CNT_MAX);
    localparam logic [4:0] INV_MAX = 5'(SH_INVLD_MAX);

    blk_sync_state_t   r_state;
    logic [6:0]        r_sh_cnt;
    logic [4:0]        r_sh_invld_cnt;
    logic [WAIT_W-1:0] r_wait;

    logic [BLK_W-1:0]  w_blk;
    logic              w_blk_stb;
    logic              w_sh_ok;
    logic [6:0]        w_sh_cnt_inc;
    logic [4:0]        w_invld_inc;

    rx_gearbox_32_66 u_gearbox (
        .i_clk     (i_pma_rx_clk),
        .i_rst_n   (i_pma_rx_rst_n),
        .i_data    (i_pma_rx),
        .o_blk     (w_blk),
        .o_blk_stb (w_blk_stb)
    );

    assign w_sh_ok      = sh_valid(w_blk[1:0]);
    assign w_sh_cnt_inc = r_sh_cnt + 7'd1;
    assign w_invld_inc  = r_sh_invld_cnt + {4'd0, ~w_sh_ok};

    // Lock FSM; block outputs are registered here so they share the gearbox-to-output cycle
    always_ff @(posedge i_pma_rx_clk) begin
        if (!i_pma_rx_rst_n) begin
            r_state        <= LOCK_INIT;
            r_sh_cnt       <= '0;
            r_sh_invld_cnt <= '0;
            r_wait         <= '0;
            o_pma_slip     <= 1'b0;
            o_blk_valid    <= 1'b0;
            o_blk_lock     <= 1'b0;
            o_blk_data     <= '0;
        end else begin
            o_pma_slip  <= 1'b0;
            o_blk_valid <= 1'b0;
            case (r_state)
                LOCK_INIT: begin
                    r_sh_cnt       <= '0;
                    r_sh_invld_cnt <= '0;
                    o_blk_lock     <= 1'b0;
                    r_state        <= TEST_SH;
                end
                TEST_SH: begin
                    if (w_blk_stb) begin
                        o_blk_valid    <= 1'b1;
                        o_blk_data     <= w_blk;
                        r_sh_cnt       <= w_sh_cnt_inc;
                        r_sh_invld_cnt <= w_invld_inc;
                        if (!o_blk_lock) begin
                            if (!w_sh_ok) begin
                                r_state <= SLIP;
                            end else if (w_sh_cnt_inc == CNT_MAX) begin
                                o_blk_lock     <= 1'b1;
                                r_sh_cnt       <= '0;
                                r_sh_invld_cnt <= '0;
                            end
                        end else if (w_invld_inc == INV_MAX) begin
                            // Unlock takes priority over a window ending on the same header
                            o_blk_lock <= 1'b0;
                            r_state    <= SLIP;
                        end else if (w_sh_cnt_inc == CNT_MAX) begin
                            r_sh_cnt       <= '0;
                            r_sh_invld_cnt <= '0;
                        end
                    end
                end
                SLIP: begin
                    o_pma_slip     <= 1'b1;
                    r_sh_cnt       <= '0;
                    r_sh_invld_cnt <= '0;
                    r_wait         <= WAIT_W'(SLIP_WAIT);
                    r_state        <= pcs_pkg::SLIP_WAIT;
                end
                default: begin
                    // Blocks produced while the PMA settles after a slip are discarded
                    if (r_wait == '0) r_state <= TEST_SH;
                    else r_wait <= r_wait - 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_block_sync.sv
// tb_rx_block_sync: directed bench with a bit-queue reference model of gearbox and lock rules
module tb_rx_block_sync;

    localparam int SH_CNT_MAX   = 64;
    localparam int SH_INVLD_MAX = 16;
    localparam int SLIP_WAIT    = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pma_rx = '0;
    logic        slip, valid, lock;
    logic [65:0] data;

    rx_block_sync #(
        .SH_CNT_MAX   (SH_CNT_MAX),
        .SH_INVLD_MAX (SH_INVLD_MAX),
        .SLIP_WAIT    (SLIP_WAIT)
    ) dut (
        .i_pma_rx_clk   (clk),
        .i_pma_rx_rst_n (rst_n),
        .i_pma_rx       (pma_rx),
        .o_pma_slip     (slip),
        .o_blk_data     (data),
        .o_blk_valid    (valid),
        .o_blk_lock     (lock)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit          tx[$];
    logic [1:0]  sched[$];
    logic [65:0] src_q[$];
    bit          trk = 0;
    bit          en = 0;
    int          k = 0;
    int          vcnt = 0;
    int          nslip = 0;
    int          last_slip = -1000;
    logic        prev_valid = 1'b0;

    bit          mq[$];
    bit          m_lock;
    int          m_cnt, m_inv, m_slip_at, m_resume;
    logic        e_valid = 1'b0, e_lock = 1'b0, e_slip = 1'b0;
    logic [65:0] e_data = '0;

    task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, k);
        end
    endtask

    // Reference: serial bit queue gearbox plus window/slip rules expressed as cycle arithmetic
    task automatic model_step(input logic [31:0] w, input bit r);
        logic [65:0] b;
        bit bad;
        if (!r) begin
            mq.delete();
            m_lock = 0; m_cnt = 0; m_inv = 0; m_slip_at = -1; m_resume = 0;
            e_valid = 0; e_lock = 0; e_slip = 0; e_data = '0;
            return;
        end
        e_slip  = (k == m_slip_at);
        e_valid = 0;
        for (int i = 0; i < 32; i++) mq.push_back(w[i]);
        if (mq.size() >= 66) begin
            for (int i = 0; i < 66; i++) b[i] = mq.pop_front();
            if (k >= m_resume) begin
                e_valid = 1;
                e_data  = b;
                bad = (b[1:0] == 2'b00) || (b[1:0] == 2'b11);
                m_cnt++;
                if (bad) m_inv++;
                if ((!m_lock && bad) || (m_lock && m_inv == SH_INVLD_MAX)) begin
                    m_lock = 0; m_cnt = 0; m_inv = 0;
                    m_slip_at = k + 1;
                    m_resume  = k + SLIP_WAIT + 3;
                end else if (m_cnt == SH_CNT_MAX) begin
                    m_lock = 1; m_cnt = 0; m_inv = 0;
                end
            end
        end
        e_lock = m_lock;
    endtask

    task automatic compare_cycle();
        if (!en) return;
        check("slip", {65'd0, slip}, {65'd0, e_slip});
        check("valid", {65'd0, valid}, {65'd0, e_valid});
        check("lock", {65'd0, lock}, {65'd0, e_lock});
        if (e_valid === 1'b1) check("data", data, e_data);
        if (valid === 1'b1) begin
            check("gap", {65'd0, prev_valid}, 66'd0);
            if (trk) begin
                if (src_q.size() == 0) check("src_underrun", 66'd1, 66'd0);
                else check("src_data", data, src_q.pop_front());
            end
        end
        prev_valid = valid;
    endtask

    task automatic push_next();
        logic [65:0] b;
        logic [1:0]  h;
        h = (sched.size() != 0) ? sched.pop_front() : ($urandom_range(0, 1) != 0 ? 2'b01 : 2'b10);
        b = {$urandom(), $urandom(), h};
        for (int i = 0; i < 66; i++) tx.push_back(b[i]);
        if (trk) src_q.push_back(b);
    endtask

    task automatic tick(input bit r);
        logic [31:0] w;
        @(negedge clk);
        compare_cycle();
        k++;
        if (valid === 1'b1) vcnt++;
        w = '0;
        if (!r) begin
            tx.delete();
            src_q.delete();
            vcnt = 0;
            last_slip = -1000;
        end else begin
            while (tx.size() < 33) push_next();
            if (slip === 1'b1) begin
                nslip++;
                check("slip_spacing", {65'd0, (k - last_slip) >= SLIP_WAIT + 1}, 66'd1);
                last_slip = k;
                void'(tx.pop_front());
            end
            for (int i = 0; i < 32; i++) w[i] = tx.pop_front();
        end
        rst_n  = r;
        pma_rx = w;
        model_step(w, r);
    endtask

    task automatic reset_pulse(input string name);
        tick(0);
        sched.delete();
        @(posedge clk);
        #1;
        check({name, "_slip"}, {65'd0, slip}, 66'd0);
        check({name, "_valid"}, {65'd0, valid}, 66'd0);
        check({name, "_lock"}, {65'd0, lock}, 66'd0);
        check({name, "_data"}, data, 66'd0);
    endtask

    task automatic lock_edge(input string name);
        if (valid === 1'b1 && vcnt == 63) check({name, "_lock63"}, {65'd0, lock}, 66'd0);
        if (valid === 1'b1 && vcnt == 64) check({name, "_lock64"}, {65'd0, lock}, 66'd1);
    endtask

    task automatic relock(input string name);
        bit done;
        done = 0;
        for (int t = 0; t < 400 && !done; t++) begin
            tick(1);
            lock_edge(name);
            done = (valid === 1'b1 && vcnt == 64);
        end
        check({name, "_reached"}, {65'd0, done}, 66'd1);
    endtask

    initial begin
        int drops;
        bit hit;
        int inv_i;

        // Aligned clean stream, rate and lock-at-64
        reset_pulse("rst_init");
        en = 1;
        trk = 1;
        nslip = 0;
        for (int t = 1; t <= 4200; t++) begin
            tick(1);
            lock_edge("clean");
            if (t == 3) check("first_blk_t3", vcnt, 0);
            if (t == 4) check("first_blk_t4", vcnt, 1);
            if (t == 3301) check("rate_3300_words", vcnt, 1600);
        end
        check("clean_nslip", nslip, 0);
        check("clean_blocks", {65'd0, vcnt >= 2000}, 66'd1);
        trk = 0;

        // Sparse errors for 10 windows, then a window whose 16th invalid is its 64th header
        reset_pulse("rst_sparse");
        nslip = 0;
        inv_i = 0;
        for (int i = 0; i < 64; i++) sched.push_back(2'b01);
        for (int w = 1; w <= 11; w++)
            for (int p = 1; p <= 64; p++) begin
                if ((p % 4 == 1 && p <= 57) || (w == 11 && p == 64)) begin
                    sched.push_back(inv_i[0] ? 2'b11 : 2'b00);
                    inv_i++;
                end else begin
                    sched.push_back(p[0] ? 2'b10 : 2'b01);
                end
            end
        drops = 0;
        hit = 0;
        for (int t = 0; t < 2000 && !hit; t++) begin
            tick(1);
            lock_edge("sparse");
            if (vcnt >= 64 && vcnt < 768 && lock !== 1'b1) drops++;
            if (valid === 1'b1 && vcnt == 767) check("loss_prev_lock", {65'd0, lock}, 66'd1);
            if (valid === 1'b1 && vcnt == 768) begin
                hit = 1;
                check("loss_lock", {65'd0, lock}, 66'd0);
                check("loss_hdr", {64'd0, data[1:0]}, 66'd3);
                check("loss_slip_same", {65'd0, slip}, 66'd0);
                check("sparse_nslip", nslip, 0);
                tick(1);
                check("loss_slip_next", {65'd0, slip}, 66'd1);
            end
        end
        check("loss_reached", {65'd0, hit}, 66'd1);
        check("sparse_lock_drops", drops, 0);

        // Reset during SLIP_WAIT, relock, then reset while locked and relock
        for (int t = 0; t < 5; t++) tick(1);
        reset_pulse("rst_slipwait");
        relock("relock1");
        while (vcnt < 100) tick(1);
        check("pre_rst_lock", {65'd0, lock}, 66'd1);
        reset_pulse("rst_locked");
        relock("relock2");

        // Stream offset by 37 bits; each slip drops one bit at the PMA
        reset_pulse("rst_misalign");
        nslip = 0;
        for (int i = 0; i < 37; i++) tx.push_back($urandom_range(0, 1) != 0);
        hit = 0;
        for (int t = 0; t < 6000 && !hit; t++) begin
            tick(1);
            hit = (lock === 1'b1);
        end
        check("misalign_locked", {65'd0, hit}, 66'd1);
        check("misalign_nslip", nslip, 37);
        for (int t = 0; t < 400; t++) tick(1);
        check("misalign_hold", {65'd0, lock}, 66'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
